ram_array: RTL and testbench

RAM_ARRAY -- requirements
Module: ram_array

---
 rtl/ram_array_pkg.sv | 32 +++
 rtl/ram_array_ram512x8.sv | 57 +++++
 rtl/ram_array.sv | 180 ++++++++++++++++++
 tb/tb_ram_array.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_array_pkg.sv
// ram_array_pkg -- shared constants, FSM state type and sizing helpers for
// the banked ram_array and its 512x8 macro wrapper.
//   MACRO_DEPTH  words per macro
//   MACRO_WIDTH  bits per macro word (one byte lane)
//   state_t      controller states (ST_INIT only reachable with RAM_ARRAY_INIT_EN)
//   bank_count() number of macro rows for a given array depth
//   dw_legal() / depth_legal()  parameter legality checks used at elaboration
package ram_array_pkg;

    localparam int MACRO_DEPTH = 512;
    localparam int MACRO_WIDTH = 8;
    localparam int MACRO_AW    = $clog2(MACRO_DEPTH);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int bank_count(input int depth);
        return depth / MACRO_DEPTH;
    endfunction

    function automatic bit dw_legal(input int dw);
        return (dw % MACRO_WIDTH == 0) && (dw >= 8) && (dw <= 64);
    endfunction

    function automatic bit depth_legal(input int depth);
        return (depth >= 512) && (depth <= 4096) &&
               (depth % MACRO_DEPTH == 0) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/ram_array_ram512x8.sv
// ram512x8 -- wrapper around one 512x8 single-port SRAM macro.
//   clk_i  macro clock (rising edge)
//   ce     chip enable; macro idle and low-power when 0
//   we     1=write din to adr, 0=read adr into dout
//   adr    word address
//   din    write data
//   dout   read data, registered, updated only by an enabled read
// Macros: SIM selects the behavioural model; USE_POWER_PINS adds VDD/VSS.
module ram512x8
    import ram_array_pkg::*;
(
`ifdef USE_POWER_PINS
    inout  wire                    VDD,
    inout  wire                    VSS,
`endif
    input  logic                   clk_i,
    input  logic                   ce,
    input  logic                   we,
    input  logic [MACRO_AW-1:0]    adr,
    input  logic [MACRO_WIDTH-1:0] din,
    output logic [MACRO_WIDTH-1:0] dout
);

`ifdef SIM
    logic [MACRO_WIDTH-1:0] mem [MACRO_DEPTH];

    always_ff @(posedge clk_i) begin
        if (ce) begin
            if (we) begin
                mem[adr] <= din;
            end else begin
                dout <= mem[adr];
            end
        end
    end
`else
    // Synthesis view: plain inferable single-port array with the macro's
    // read-register behaviour; the hardening flow binds the foundry cell
    // behind this same port list.
    logic [MACRO_WIDTH-1:0] array_q [MACRO_DEPTH];
    logic                   do_write;
    logic                   do_read;

    assign do_write = ce & we;
    assign do_read  = ce & ~we;

    always_ff @(posedge clk_i) begin
        if (do_write) begin
            array_q[adr] <= din;
        end
        if (do_read) begin
            dout <= array_q[adr];
        end
    end
`endif

endmodule

// File: rtl/ram_array.sv
// ram_array -- banked word RAM built from a grid of 512x8 macros.
// DEPTH/512 banks by DW/8 byte lanes; adr[8:0] is the in-bank address and
// adr[MSB:9] selects the bank. Single request port, fixed one-cycle read
// latency, byte-lane write enables, no response back-pressure.
//   clk_i        clock, all logic on rising edge
//   rst_i        synchronous reset, active-high
//   req_valid_i  request present
//   req_ready_o  request accepted when valid & ready
//   req_we_i     1=write, 0=read
//   req_be_i     byte-lane write enables
//   req_adr_i    word address
//   req_dat_i    write data
//   rsp_valid_o  one-cycle pulse, read data valid
//   rsp_dat_o    read data (zero whenever rsp_valid_o is low)
// Macros: RAM_ARRAY_INIT_EN adds a 512-cycle zero-fill sweep after reset;
//         USE_POWER_PINS adds VDD/VSS routed to every macro.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_INIT | zero-fill sweep, all macros written in parallel, ready low
// ST_RUN  | normal operation, one request per cycle, ready high
module ram_array
    import ram_array_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 1024
) (
`ifdef USE_POWER_PINS
    inout  wire                     VDD,
    inout  wire                     VSS,
`endif
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_we_i,
    input  logic [DW/8-1:0]         req_be_i,
    input  logic [$clog2(DEPTH)-1:0] req_adr_i,
    input  logic [DW-1:0]           req_dat_i,
    output logic                    rsp_valid_o,
    output logic [DW-1:0]           rsp_dat_o
);

    localparam int AW  = $clog2(DEPTH);
    localparam int NB  = bank_count(DEPTH);
    localparam int NL  = DW / MACRO_WIDTH;
    localparam int BSW = (NB > 1) ? $clog2(NB) : 1;

    if (!dw_legal(DW)) begin : g_bad_dw
        $error("ram_array: DW=%0d must be a multiple of 8 in 8..64", DW);
    end
    if (!depth_legal(DEPTH)) begin : g_bad_depth
        $error("ram_array: DEPTH=%0d must be a power of two in 512..4096", DEPTH);
    end

    state_t               state;
    logic                 ready_q;
    logic                 rsp_valid_q;
    logic [BSW-1:0]       rd_bank_q;
    logic [BSW-1:0]       req_bank;
    logic                 accept;
    logic                 rd_accept;
    logic                 sweeping;
    logic                 mac_we;
    logic [MACRO_AW-1:0]  mac_adr;
    logic [DW-1:0]        mac_din;
    logic [NB-1:0]        bank_ce;
    logic [DW-1:0]        bank_q [NB];
    logic [DW-1:0]        rd_word;

    if (NB > 1) begin : g_bank_sel
        assign req_bank = req_adr_i[AW-1:MACRO_AW];
    end else begin : g_single_bank
        assign req_bank = '0;
    end

    // Reset forces ready low immediately, not one edge later.
    assign req_ready_o = ready_q & ~rst_i;
    assign accept      = req_valid_i & req_ready_o;
    assign rd_accept   = accept & ~req_we_i;

`ifdef RAM_ARRAY_INIT_EN
    localparam logic [MACRO_AW-1:0] SWEEP_LAST = MACRO_AW'(MACRO_DEPTH - 1);
    logic [MACRO_AW-1:0] sweep_cnt;

    assign sweeping = (state == ST_INIT) & ~rst_i;
    assign mac_adr  = sweeping ? sweep_cnt : req_adr_i[MACRO_AW-1:0];
`else
    assign sweeping = 1'b0;
    assign mac_adr  = req_adr_i[MACRO_AW-1:0];
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
`ifdef RAM_ARRAY_INIT_EN
            state     <= ST_INIT;
            ready_q   <= 1'b0;
            sweep_cnt <= '0;
`else
            // Output is gated by rst_i, so ready appears the first cycle
            // after reset drops.
            state     <= ST_RUN;
            ready_q   <= 1'b1;
`endif
        end else begin
            case (state)
`ifdef RAM_ARRAY_INIT_EN
                ST_INIT: begin
                    if (sweep_cnt == SWEEP_LAST) begin
                        state   <= ST_RUN;
                        ready_q <= 1'b1;
                    end else begin
                        sweep_cnt <= sweep_cnt + 1'b1;
                    end
                end
`endif
                ST_RUN: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= ST_RUN;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Bank of an accepted read is captured so the output mux follows the
    // macro read register, even for back-to-back reads across banks.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rd_bank_q   <= '0;
        end else begin
            rsp_valid_q <= rd_accept;
            if (rd_accept) begin
                rd_bank_q <= req_bank;
            end
        end
    end

    assign mac_we  = sweeping | req_we_i;
    assign mac_din = sweeping ? '0 : req_dat_i;

    for (genvar b = 0; b < NB; b++) begin : g_bank
        logic [DW-1:0] q_word;

        assign bank_ce[b] = accept & (req_bank == BSW'(b));
        assign bank_q[b]  = q_word;

        for (genvar k = 0; k < NL; k++) begin : g_lane
            logic lane_ce;

            // Lanes with be=0 stay disabled on writes so their contents
            // and read registers are untouched.
            assign lane_ce = sweeping | (bank_ce[b] & (~req_we_i | req_be_i[k]));

            ram512x8 u_macro (
`ifdef USE_POWER_PINS
                .VDD   (VDD),
                .VSS   (VSS),
`endif
                .clk_i (clk_i),
                .ce    (lane_ce),
                .we    (mac_we),
                .adr   (mac_adr),
                .din   (mac_din[k*MACRO_WIDTH +: MACRO_WIDTH]),
                .dout  (q_word[k*MACRO_WIDTH +: MACRO_WIDTH])
            );
        end
    end

    always_comb begin
        rd_word = bank_q[rd_bank_q];
    end

    assign rsp_valid_o = rsp_valid_q & ~rst_i;
    assign rsp_dat_o   = rsp_valid_o ? rd_word : '0;

endmodule

// File: tb/tb_ram_array.sv
module tb_ram_array;

    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int NL    = DW / 8;
    localparam int AW    = 10;

`ifdef RAM_ARRAY_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic          req_we_i = 1'b0;
    logic [NL-1:0] req_be_i = '0;
    logic [AW-1:0] req_adr_i = '0;
    logic [DW-1:0] req_dat_i = '0;
    logic          rsp_valid_o;
    logic [DW-1:0] rsp_dat_o;

`ifdef USE_POWER_PINS
    wire vdd = 1'b1;
    wire vss = 1'b0;
`endif

    ram_array #(.DW(DW), .DEPTH(DEPTH)) dut (
`ifdef USE_POWER_PINS
        .VDD         (vdd),
        .VSS         (vss),
`endif
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_be_i    (req_be_i),
        .req_adr_i   (req_adr_i),
        .req_dat_i   (req_dat_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_dat_o   (rsp_dat_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    // Reference model: byte-addressed storage with per-byte "known" flags.
    logic [7:0] m_byte  [DEPTH][NL];
    bit         m_known [DEPTH][NL];

    typedef struct {
        bit            we;
        logic [NL-1:0] be;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic model_clear(input bit known_zero);
        for (int a = 0; a < DEPTH; a++) begin
            for (int k = 0; k < NL; k++) begin
                m_byte[a][k]  = 8'h00;
                m_known[a][k] = known_zero;
            end
        end
    endtask

    task automatic model_write(input logic [AW-1:0] adr, input logic [NL-1:0] be,
                               input logic [DW-1:0] dat);
        for (int k = 0; k < NL; k++) begin
            if (be[k]) begin
                m_byte[adr][k]  = dat[k*8 +: 8];
                m_known[adr][k] = 1'b1;
            end
        end
    endtask

    task automatic model_read(input logic [AW-1:0] adr, output logic [DW-1:0] dat,
                              output logic [DW-1:0] mask);
        for (int k = 0; k < NL; k++) begin
            dat[k*8 +: 8]  = m_byte[adr][k];
            mask[k*8 +: 8] = m_known[adr][k] ? 8'hFF : 8'h00;
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // One request cycle; returns the response seen after the edge.
    task automatic issue(input bit v, input bit we, input logic [NL-1:0] be,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         output logic got_valid, output logic [DW-1:0] got_dat);
        logic [DW-1:0] e_dat;
        logic [DW-1:0] e_mask;
        logic [1:0]    e_ce;
        req_valid_i = v;
        req_we_i    = we;
        req_be_i    = be;
        req_adr_i   = adr;
        req_dat_i   = dat;
        #1;
        e_ce = v ? (2'b01 << adr[AW-1]) : 2'b00;
        if (v) chk("ready_run", req_ready_o, 1'b1);
        chk("bank_ce", dut.bank_ce, e_ce);
        model_read(adr, e_dat, e_mask);
        if (v && we) model_write(adr, be, dat);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        got_valid = rsp_valid_o;
        got_dat   = rsp_dat_o;
        chk("rsp_valid", rsp_valid_o, v && !we);
        if (v && !we && e_mask != '0) begin
            chk("rsp_model", rsp_dat_o & e_mask, e_dat & e_mask);
        end
    endtask

    task automatic reset_and_release();
        int n;
        rst_i       = 1'b1;
        req_valid_i = 1'b1;
        repeat (3) begin
            step();
            chk("rst_ready", req_ready_o, 1'b0);
            chk("rst_rsp_valid", rsp_valid_o, 1'b0);
            chk("rst_rsp_dat", rsp_dat_o, '0);
            chk("rst_bank_ce", dut.bank_ce, 2'b00);
        end
        req_valid_i = 1'b0;
        rst_i = 1'b0;
        model_clear(INIT_EN);
        #1;
        if (INIT_EN) begin
            n = 0;
            while (!req_ready_o && n < 600) begin
                n++;
                step();
            end
            chk("init_ready_low_cycles", n, 512);
            chk("init_ready_after", req_ready_o, 1'b1);
        end else begin
            chk("ready_first_cycle", req_ready_o, 1'b1);
        end
    endtask

    logic          gv;
    logic [DW-1:0] gd;
    logic [AW-1:0] hot [8];

    initial begin
        hot[0] = 10'h000; hot[1] = 10'h001; hot[2] = 10'h1FF; hot[3] = 10'h200;
        hot[4] = 10'h201; hot[5] = 10'h3FF; hot[6] = 10'h0AA; hot[7] = 10'h2AA;

        tbl.push_back('{1'b1, 4'b1111, 10'h005, 32'h11223344, 32'h0});
        tbl.push_back('{1'b1, 4'b0101, 10'h005, 32'hAABBCCDD, 32'h0});
        tbl.push_back('{1'b0, 4'b0000, 10'h005, 32'h0,        32'h11BB33DD});
        tbl.push_back('{1'b1, 4'b1111, 10'h1FF, 32'hCAFEF00D, 32'h0});
        tbl.push_back('{1'b1, 4'b1111, 10'h200, 32'hDEADBEEF, 32'h0});
        tbl.push_back('{1'b0, 4'b0000, 10'h1FF, 32'h0,        32'hCAFEF00D});
        tbl.push_back('{1'b0, 4'b0000, 10'h200, 32'h0,        32'hDEADBEEF});
        tbl.push_back('{1'b1, 4'b1111, 10'h010, 32'h5A5A5A5A, 32'h0});
        tbl.push_back('{1'b0, 4'b0000, 10'h010, 32'h0,        32'h5A5A5A5A});
        tbl.push_back('{1'b1, 4'b0000, 10'h010, 32'h12345678, 32'h0});
        tbl.push_back('{1'b0, 4'b0000, 10'h010, 32'h0,        32'h5A5A5A5A});
        tbl.push_back('{1'b1, 4'b1111, 10'h3FF, 32'h00000000, 32'h0});
        tbl.push_back('{1'b1, 4'b1000, 10'h3FF, 32'hFFFFFFFF, 32'h0});
        tbl.push_back('{1'b0, 4'b0000, 10'h3FF, 32'h0,        32'hFF000000});
        tbl.push_back('{1'b0, 4'b0000, 10'h005, 32'h0,        32'h11BB33DD});

        reset_and_release();

        if (INIT_EN) begin
            issue(1'b1, 1'b0, 4'b0000, 10'h3FF, '0, gv, gd);
            chk("init_read_3ff", gd, 32'h00000000);
        end

        foreach (tbl[i]) begin
            issue(1'b1, tbl[i].we, tbl[i].be, tbl[i].adr, tbl[i].dat, gv, gd);
            if (!tbl[i].we) chk($sformatf("tbl_rd_%0d", i), gd, tbl[i].exp);
        end

        for (int i = 0; i < 1000; i++) begin
            logic          v;
            logic          we;
            logic [NL-1:0] be;
            logic [AW-1:0] adr;
            logic [DW-1:0] dat;
            v   = ($urandom_range(0, 9) < 8);
            we  = $urandom_range(0, 1);
            be  = NL'($urandom_range(0, 15));
            adr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1))
                                              : hot[$urandom_range(0, 7)];
            dat = $urandom;
            issue(v, we, be, adr, dat, gv, gd);
        end

        // Reset in the cycle after an accepted read suppresses the response.
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_adr_i   = 10'h005;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        rst_i = 1'b1;
        #1;
        chk("midread_rsp_valid", rsp_valid_o, 1'b0);
        step();
        chk("midread_rsp_valid_after", rsp_valid_o, 1'b0);
        reset_and_release();

        issue(1'b1, 1'b1, 4'b1111, 10'h123, 32'h0BADCAFE, gv, gd);
        issue(1'b1, 1'b0, 4'b0000, 10'h123, '0, gv, gd);
        chk("post_reset_rd", gd, 32'h0BADCAFE);
        chk("post_reset_valid", gv, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
